// File: rtl/id_char_packer.sv
// id_char_packer
//   Front end of the ID checker. Collects one frame of ASCII ID characters
//   (1 uppercase letter followed by 9 digits), maps each character to a 6-bit
//   symbol, checks the frame format, and replays a well-formed frame to the
//   checker as one contiguous FRAME_LEN-cycle burst, followed by GAP_CYCLES
//   idle cycles so the checker can finish its result/clear cycles.
//
// Ports
//   clk         in   1  rising-edge clock
//   rst_n       in   1  asynchronous active-low reset
//   char_valid  in   1  char_data holds a character
//   char_data   in   8  ASCII character
//   char_ready  out  1  block can accept a character (decoded from state)
//   id_valid    out  1  symbol valid (checker in_valid), registered
//   id_sym      out  6  mapped symbol (checker in_id), registered
//   fmt_err     out  1  one-cycle pulse: the frame just collected was malformed
//   err_pos     out  4  index of the first bad character, valid with fmt_err
//
// Handshake: a character is transferred on a rising edge where
//   char_valid && char_ready. char_valid may drop at any time (bubbles). While
//   char_ready is low the character is not taken and the source must hold it.
//   id_valid has no back-pressure: the burst is always FRAME_LEN cycles long.

module id_char_packer #(
  parameter int FRAME_LEN  = 10,  // must fit the 4-bit count/err_pos (<= 15)
  parameter int GAP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       char_valid,
  input  logic [7:0] char_data,
  output logic       char_ready,
  output logic       id_valid,
  output logic [5:0] id_sym,
  output logic       fmt_err,
  output logic [3:0] err_pos
);

  localparam int CW = 4;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    SEND    = 2'd1,
    GAP     = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [5:0]    sym_q [FRAME_LEN];
  logic [5:0]    sym_d [FRAME_LEN];
  logic          err_q, err_d;
  logic [CW-1:0] first_bad_q, first_bad_d;
  logic          id_valid_q, id_valid_d;
  logic [5:0]    id_sym_q, id_sym_d;
  logic          fmt_err_q, fmt_err_d;
  logic [3:0]    err_pos_q, err_pos_d;

  logic          accept;
  logic          bad_char;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  function automatic logic is_upper(input logic [7:0] c);
    return (c >= 8'h41) && (c <= 8'h5A);
  endfunction

  // Digits map to their value; letters follow the checker's alphabet order,
  // in which I and O come last and W sits between Y and Z.
  function automatic logic [5:0] map_sym(input logic [7:0] c);
    logic [5:0] s;
    s = 6'd0;
    if (c >= 8'h30 && c <= 8'h39) begin
      s = {2'b00, c[3:0]};
    end else begin
      case (c)
        8'h41: s = 6'd10;  // A
        8'h42: s = 6'd11;  // B
        8'h43: s = 6'd12;  // C
        8'h44: s = 6'd13;  // D
        8'h45: s = 6'd14;  // E
        8'h46: s = 6'd15;  // F
        8'h47: s = 6'd16;  // G
        8'h48: s = 6'd17;  // H
        8'h4A: s = 6'd18;  // J
        8'h4B: s = 6'd19;  // K
        8'h4C: s = 6'd20;  // L
        8'h4D: s = 6'd21;  // M
        8'h4E: s = 6'd22;  // N
        8'h50: s = 6'd23;  // P
        8'h51: s = 6'd24;  // Q
        8'h52: s = 6'd25;  // R
        8'h53: s = 6'd26;  // S
        8'h54: s = 6'd27;  // T
        8'h55: s = 6'd28;  // U
        8'h56: s = 6'd29;  // V
        8'h58: s = 6'd30;  // X
        8'h59: s = 6'd31;  // Y
        8'h57: s = 6'd32;  // W
        8'h5A: s = 6'd33;  // Z
        8'h49: s = 6'd34;  // I
        8'h4F: s = 6'd35;  // O
        default: s = 6'd0;
      endcase
    end
    return s;
  endfunction

  assign char_ready = (state_q == COLLECT);
  assign accept     = char_valid && char_ready;
  assign bad_char   = (count_q == '0) ? !is_upper(char_data) : !is_digit(char_data);

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    sym_d       = sym_q;
    err_d       = err_q;
    first_bad_d = first_bad_q;
    id_valid_d  = 1'b0;
    id_sym_d    = 6'd0;
    fmt_err_d   = 1'b0;
    err_pos_d   = err_pos_q;

    case (state_q)
      COLLECT: begin
        if (accept) begin
          sym_d[count_q] = map_sym(char_data);
          if (bad_char && !err_q) begin
            err_d       = 1'b1;
            first_bad_d = count_q;
          end
          if (count_q == CW'(FRAME_LEN - 1)) begin
            count_d = '0;
            err_d   = 1'b0;
            if (err_q || bad_char) begin
              // The last character itself can be the first failure.
              fmt_err_d = 1'b1;
              err_pos_d = err_q ? first_bad_q : count_q;
            end else begin
              state_d    = SEND;
              id_valid_d = 1'b1;
              id_sym_d   = sym_q[0];
              // In SEND count indexes the next symbol to emit.
              count_d    = CW'(1);
            end
          end else begin
            count_d = count_q + 4'd1;
          end
        end
      end

      SEND: begin
        if (count_q == CW'(FRAME_LEN)) begin
          state_d = GAP;
          count_d = '0;
        end else begin
          id_valid_d = 1'b1;
          id_sym_d   = sym_q[count_q];
          count_d    = count_q + 4'd1;
        end
      end

      GAP: begin
        if (count_q == CW'(GAP_CYCLES - 1)) begin
          state_d = COLLECT;
          count_d = '0;
        end else begin
          count_d = count_q + 4'd1;
        end
      end

      default: begin
        state_d = COLLECT;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= COLLECT;
      count_q     <= '0;
      err_q       <= 1'b0;
      first_bad_q <= '0;
      id_valid_q  <= 1'b0;
      id_sym_q    <= 6'd0;
      fmt_err_q   <= 1'b0;
      err_pos_q   <= 4'd0;
      for (int i = 0; i < FRAME_LEN; i++) begin
        sym_q[i] <= 6'd0;
      end
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      err_q       <= err_d;
      first_bad_q <= first_bad_d;
      id_valid_q  <= id_valid_d;
      id_sym_q    <= id_sym_d;
      fmt_err_q   <= fmt_err_d;
      err_pos_q   <= err_pos_d;
      for (int i = 0; i < FRAME_LEN; i++) begin
        sym_q[i] <= sym_d[i];
      end
    end
  end

  assign id_valid = id_valid_q;
  assign id_sym   = id_sym_q;
  assign fmt_err  = fmt_err_q;
  assign err_pos  = err_pos_q;

endmodule

// File: tb/tb_id_char_packer.sv
// Testbench for id_char_packer: table of frames with expected first symbol or
// error position, a scoreboard of expected burst symbols and error positions,
// a negedge monitor that checks burst length, latency and char_ready timing,
// and hand-written back-to-back, bubble and mid-burst reset sequences.

module tb_id_char_packer;

  logic       clk;
  logic       rst_n;
  logic       char_valid;
  logic [7:0] char_data;
  logic       char_ready;
  logic       id_valid;
  logic [5:0] id_sym;
  logic       fmt_err;
  logic [3:0] err_pos;

  id_char_packer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .char_valid (char_valid),
    .char_data  (char_data),
    .char_ready (char_ready),
    .id_valid   (id_valid),
    .id_sym     (id_sym),
    .fmt_err    (fmt_err),
    .err_pos    (err_pos)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int tests = 0;
  int fails = 0;

  logic [5:0] exp_q[$];
  logic [3:0] err_exp_q[$];
  int         rise_q[$];

  int   cyc = 0;
  int   acc_cnt = 0;
  int   frame_end_cyc = -1;
  int   vrun = 0;
  int   rrun = 0;
  int   ready_low_total = 0;
  logic ready_prev = 1'b0;
  logic prev_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor (negedge) ----------------
  always @(negedge clk) begin
    logic [5:0] e;
    logic [3:0] p;
    logic       acc;
    cyc++;
    if (!rst_n) begin
      acc_cnt    = 0;
      vrun       = 0;
      rrun       = 0;
      prev_valid = 1'b0;
      ready_prev = char_ready;
    end else begin
      // char_valid seen now was on the bus at the preceding posedge;
      // ready_prev is char_ready as it was before that posedge.
      acc = char_valid && ready_prev;
      if (acc) begin
        acc_cnt++;
        if (acc_cnt == 10) begin
          acc_cnt       = 0;
          frame_end_cyc = cyc;
        end
      end

      if (id_valid) begin
        if (!prev_valid) begin
          check("burst_latency", cyc, frame_end_cyc);
          rise_q.push_back(cyc);
        end
        vrun++;
        if (exp_q.size() == 0) begin
          check("id_valid_unexpected", id_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("id_sym", id_sym, e);
        end
      end else if (vrun != 0) begin
        check("burst_len", vrun, 10);
        vrun = 0;
      end
      prev_valid = id_valid;

      if (!char_ready) begin
        rrun++;
        ready_low_total++;
      end else if (rrun != 0) begin
        check("ready_low_len", rrun, 12);
        rrun = 0;
      end

      if (fmt_err) begin
        if (err_exp_q.size() == 0) begin
          check("fmt_err_unexpected", fmt_err, 1'b0);
        end else begin
          p = err_exp_q.pop_front();
          check("err_pos", err_pos, p);
        end
      end
      ready_prev = char_ready;
    end
  end

  // ---------------- driver tasks ----------------
  // Entered and left at negedge+1.
  task automatic send_frame(input logic [79:0] text, input bit bubbles);
    int n;
    int guard;
    for (int i = 0; i < 10; i++) begin
      if (bubbles) begin
        n = int'($urandom_range(0, 3));
        repeat (n) begin
          char_valid = 1'b0;
          @(negedge clk); #1;
        end
      end
      char_valid = 1'b1;
      char_data  = text[79-8*i -: 8];
      guard = 0;
      while (!char_ready && guard < 50) begin
        @(negedge clk); #1;
        guard++;
      end
      if (!char_ready) check("ready_timeout", char_ready, 1'b1);
      @(negedge clk); #1;
    end
  endtask

  task automatic push_expected(input logic [79:0] text, input bit is_err,
                               input logic [3:0] pos, input logic [5:0] first);
    logic [7:0] c;
    if (is_err) begin
      err_exp_q.push_back(pos);
    end else begin
      exp_q.push_back(first);
      for (int i = 1; i < 10; i++) begin
        c = text[79-8*i -: 8] - 8'h30;
        exp_q.push_back(c[5:0]);
      end
    end
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || !char_ready || id_valid) && guard < 100) begin
      @(negedge clk); #1;
      guard++;
    end
    check("idle_exp_q_drained", exp_q.size(), 0);
    repeat (3) begin
      @(negedge clk); #1;
    end
    check("err_q_drained", err_exp_q.size(), 0);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [79:0] text;
    bit          err;
    logic [3:0]  pos;
    logic [5:0]  first;
  } vec_t;

  vec_t vecs[15];

  initial begin
    int rl0;
    int nr0;
    int n;

    vecs[0]  = '{text: "A123456789", err: 1'b0, pos: 4'd0, first: 6'd10};
    vecs[1]  = '{text: "I012345678", err: 1'b0, pos: 4'd0, first: 6'd34};
    vecs[2]  = '{text: "O012345678", err: 1'b0, pos: 4'd0, first: 6'd35};
    vecs[3]  = '{text: "W012345678", err: 1'b0, pos: 4'd0, first: 6'd32};
    vecs[4]  = '{text: "X012345678", err: 1'b0, pos: 4'd0, first: 6'd30};
    vecs[5]  = '{text: "Y012345678", err: 1'b0, pos: 4'd0, first: 6'd31};
    vecs[6]  = '{text: "Z012345678", err: 1'b0, pos: 4'd0, first: 6'd33};
    vecs[7]  = '{text: "H987654321", err: 1'b0, pos: 4'd0, first: 6'd17};
    vecs[8]  = '{text: "a123456789", err: 1'b1, pos: 4'd0, first: 6'd0};
    vecs[9]  = '{text: "A12345678X", err: 1'b1, pos: 4'd9, first: 6'd0};
    vecs[10] = '{text: "AB23456789", err: 1'b1, pos: 4'd1, first: 6'd0};
    vecs[11] = '{text: "1A23456789", err: 1'b1, pos: 4'd0, first: 6'd0};
    vecs[12] = '{text: "@123456789", err: 1'b1, pos: 4'd0, first: 6'd0};
    vecs[13] = '{text: "[123456789", err: 1'b1, pos: 4'd0, first: 6'd0};
    vecs[14] = '{text: "A123:56789", err: 1'b1, pos: 4'd4, first: 6'd0};

    // Reset state
    char_valid = 1'b0;
    char_data  = 8'h00;
    rst_n      = 1'b1;
    #1 rst_n   = 1'b0;
    #1;
    check("rst_id_valid", id_valid, 1'b0);
    check("rst_id_sym",   id_sym,   6'd0);
    check("rst_fmt_err",  fmt_err,  1'b0);
    check("rst_err_pos",  err_pos,  4'd0);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("rst_char_ready", char_ready, 1'b1);

    // Table-driven frames, char_valid held high within each frame
    for (int v = 0; v < 15; v++) begin
      rl0 = ready_low_total;
      nr0 = rise_q.size();
      push_expected(vecs[v].text, vecs[v].err, vecs[v].pos, vecs[v].first);
      send_frame(vecs[v].text, 1'b0);
      char_valid = 1'b0;
      wait_idle();
      if (vecs[v].err) begin
        check("err_no_ready_drop", ready_low_total - rl0, 0);
        check("err_no_burst", rise_q.size() - nr0, 0);
      end else begin
        check("one_burst", rise_q.size() - nr0, 1);
      end
    end

    // Two frames back-to-back with char_valid always high
    nr0 = rise_q.size();
    push_expected("D111111111", 1'b0, 4'd0, 6'd13);
    push_expected("E000000000", 1'b0, 4'd0, 6'd14);
    send_frame("D111111111", 1'b0);
    send_frame("E000000000", 1'b0);
    char_valid = 1'b0;
    wait_idle();
    n = rise_q.size();
    check("b2b_bursts", n - nr0, 2);
    if (n - nr0 >= 2) check("b2b_spacing", rise_q[n-1] - rise_q[n-2], 22);

    // Random bubbles within a valid frame
    nr0 = rise_q.size();
    push_expected("A123456789", 1'b0, 4'd0, 6'd10);
    send_frame("A123456789", 1'b1);
    char_valid = 1'b0;
    wait_idle();
    check("bubble_burst", rise_q.size() - nr0, 1);

    // Reset during the 5th cycle of SEND
    push_expected("B123456789", 1'b0, 4'd0, 6'd11);
    send_frame("B123456789", 1'b0);
    char_valid = 1'b0;
    check("send_started", id_valid, 1'b1);
    repeat (4) begin
      @(negedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check("midrst_id_valid",   id_valid,   1'b0);
    check("midrst_id_sym",     id_sym,     6'd0);
    check("midrst_fmt_err",    fmt_err,    1'b0);
    check("midrst_err_pos",    err_pos,    4'd0);
    check("midrst_char_ready", char_ready, 1'b1);
    exp_q.delete();
    @(negedge clk); #1;
    rst_n = 1'b1;
    #1;

    nr0 = rise_q.size();
    push_expected("C123456789", 1'b0, 4'd0, 6'd12);
    send_frame("C123456789", 1'b0);
    char_valid = 1'b0;
    wait_idle();
    check("post_rst_burst", rise_q.size() - nr0, 1);

    check("final_exp_q", exp_q.size(), 0);
    check("final_err_q", err_exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
